// File: rtl/video_gearbox_pkg.sv
// Shared types and helpers for the wide-to-narrow pixel gearbox.
package video_gearbox_pkg;

  typedef enum logic [0:0] {StIdle, StRun} frame_st_e;

  // Width needed to hold a lane count of 1..lanes.
  function automatic int unsigned lcw_of(input int unsigned lanes);
    return $clog2(lanes + 1);
  endfunction

  // Bit offset of emitted lane idx within a packed word.
  function automatic int unsigned lane_off(input int unsigned idx, input int unsigned lanes,
                                           input int unsigned pix_w, input bit msb_first);
    return msb_first ? (lanes - 1 - idx) * pix_w : idx * pix_w;
  endfunction

endpackage

// File: rtl/video_gearbox_down_gbx_sync_fifo.sv
// Single-clock FIFO with synchronous flush; a write in the flush cycle lands in slot 0.
module gbx_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16,
  localparam int unsigned AW = $clog2(Depth)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_wr_en,
  input  logic [Width-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [Width-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [Width-1:0] r_mem [Depth];
  logic [AW-1:0]    w_wr_addr;

  assign o_level   = r_wr_ptr - r_rd_ptr;
  assign o_full    = (o_level == (AW + 1)'(Depth));
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign w_wr_addr = i_flush ? '0 : r_wr_ptr[AW-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= {{AW{1'b0}}, i_wr_en};
      r_rd_ptr <= '0;
    end else begin
      if (i_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[w_wr_addr] <= i_wr_data;
  end

endmodule

// File: rtl/video_gearbox_down.sv
// Wide-to-narrow pixel gearbox: buffers LANES-pixel words and emits one pixel per beat
// with frame tags, partial last words, frame-start flush and sticky truncation error.
module video_gearbox_down
  import video_gearbox_pkg::*;
#(
  parameter int unsigned PIX_W     = 24,
  parameter int unsigned LANES     = 4,
  parameter int unsigned DEPTH     = 16,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned LCW = lcw_of(LANES),
  localparam int unsigned WW  = PIX_W * LANES,
  localparam int unsigned LVW = $clog2(DEPTH) + 1
) (
  input  logic             I_hs_rx_clk,
  input  logic             I_rst_n,
  input  logic             I_sof,
  input  logic             I_valid,
  output logic             O_ready,
  input  logic [WW-1:0]    I_data,
  input  logic             I_last,
  input  logic [LCW-1:0]   I_lanes,
  output logic             O_valid,
  input  logic             I_ready,
  output logic [PIX_W-1:0] O_data,
  output logic             O_sof,
  output logic             O_eof,
  output logic             O_err_trunc,
  input  logic             I_err_clr,
  output logic [LVW-1:0]   O_level
);

  localparam int unsigned FW      = WW + 1 + LCW;
  localparam int unsigned HeadOff = lane_off(0, LANES, PIX_W, MSB_FIRST);

  frame_st_e r_state, w_state_d;
  logic      r_rdy, r_pend, w_pend_d, r_err, w_err_d, r_sof_pend, w_sof_pend_d;

  logic           w_full, w_empty, w_accept, w_wr_en, w_pop;
  logic [LCW-1:0] w_lanes_norm;
  logic [FW-1:0]  w_wr_data, w_rd_data;
  logic [WW-1:0]  w_h_data;
  logic [LCW-1:0] w_h_lanes;
  logic           w_h_last;

  logic [WW-1:0]    r_hold_data, w_hold_data_d;
  logic [LCW-1:0]   r_hold_lanes, w_hold_lanes_d, r_lane, w_lane_d;
  logic             r_hold_last, w_hold_last_d, r_hold_vld, w_hold_vld_d, w_hold_end;
  logic [PIX_W-1:0] w_lane_pix [LANES];
  logic [PIX_W-1:0] w_hold_pix;

  logic             r_out_vld, w_out_vld_d, r_out_sof, w_out_sof_d, r_out_eof, w_out_eof_d;
  logic [PIX_W-1:0] r_out_data, w_out_data_d;
  logic             w_adv;

  assign O_ready   = r_rdy & ~w_full;
  assign w_accept  = I_valid & O_ready;
  assign w_wr_en   = w_accept & (I_sof | (r_state == StRun));
  assign w_wr_data = {I_last, w_lanes_norm, I_data};
  assign w_h_data  = w_rd_data[WW-1:0];
  assign w_h_lanes = w_rd_data[WW +: LCW];
  assign w_h_last  = w_rd_data[FW-1];

  // Lane count is only honoured on the last word; 0 or out-of-range means a full word.
  always_comb begin
    w_lanes_norm = LCW'(LANES);
    if (I_last && (I_lanes != '0) && (I_lanes <= LCW'(LANES))) w_lanes_norm = I_lanes;
  end

  gbx_sync_fifo #(
    .Width (FW),
    .Depth (DEPTH)
  ) u_fifo (
    .i_clk     (I_hs_rx_clk),
    .i_rst_n   (I_rst_n),
    .i_flush   (I_sof),
    .i_wr_en   (w_wr_en),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (O_level)
  );

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_lane_pix[g] = r_hold_data[lane_off(g, LANES, PIX_W, MSB_FIRST) +: PIX_W];
  end

  always_comb begin
    w_hold_pix = '0;
    for (int i = 0; i < LANES; i++) begin
      if (r_lane == LCW'(i)) w_hold_pix = w_lane_pix[i];
    end
  end

  assign w_hold_end = (r_lane == r_hold_lanes - LCW'(1));
  assign w_adv      = ~r_out_vld | I_ready;

  // Frame FSM, truncation tracking and sticky error.
  always_comb begin
    w_state_d = r_state;
    w_pend_d  = r_pend;
    w_err_d   = r_err;
    if (I_sof) begin
      w_state_d = StRun;
      w_pend_d  = 1'b0;
    end
    if (w_wr_en) begin
      w_pend_d = ~I_last;
      if (I_last) w_state_d = StIdle;
    end
    if (I_err_clr) w_err_d = 1'b0;
    if (I_sof && (r_state == StRun) && r_pend) w_err_d = 1'b1;
  end

  // Unpacker: an empty holding register lets the FIFO head feed the output directly.
  always_comb begin
    w_pop          = 1'b0;
    w_hold_data_d  = r_hold_data;
    w_hold_lanes_d = r_hold_lanes;
    w_hold_last_d  = r_hold_last;
    w_hold_vld_d   = r_hold_vld;
    w_lane_d       = r_lane;
    w_out_vld_d    = r_out_vld;
    w_out_data_d   = r_out_data;
    w_out_sof_d    = r_out_sof;
    w_out_eof_d    = r_out_eof;
    w_sof_pend_d   = r_sof_pend;
    if (I_sof) begin
      w_hold_vld_d = 1'b0;
      w_lane_d     = '0;
      w_out_vld_d  = 1'b0;
      w_out_sof_d  = 1'b0;
      w_out_eof_d  = 1'b0;
      w_sof_pend_d = 1'b1;
    end else if (r_hold_vld) begin
      if (w_adv) begin
        w_out_vld_d  = 1'b1;
        w_out_data_d = w_hold_pix;
        w_out_sof_d  = r_sof_pend;
        w_out_eof_d  = r_hold_last & w_hold_end;
        w_sof_pend_d = 1'b0;
        if (!w_hold_end) begin
          w_lane_d = r_lane + LCW'(1);
        end else if (!w_empty) begin
          w_pop          = 1'b1;
          w_hold_data_d  = w_h_data;
          w_hold_lanes_d = w_h_lanes;
          w_hold_last_d  = w_h_last;
          w_lane_d       = '0;
        end else begin
          w_hold_vld_d = 1'b0;
        end
      end
    end else if (!w_empty) begin
      w_pop          = 1'b1;
      w_hold_data_d  = w_h_data;
      w_hold_lanes_d = w_h_lanes;
      w_hold_last_d  = w_h_last;
      w_hold_vld_d   = 1'b1;
      w_lane_d       = '0;
      if (w_adv) begin
        w_out_vld_d  = 1'b1;
        w_out_data_d = w_h_data[HeadOff +: PIX_W];
        w_out_sof_d  = r_sof_pend;
        w_out_eof_d  = w_h_last & (w_h_lanes == LCW'(1));
        w_sof_pend_d = 1'b0;
        w_hold_vld_d = (w_h_lanes != LCW'(1));
        w_lane_d     = LCW'(1);
      end
    end else if (w_adv) begin
      w_out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge I_hs_rx_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state      <= StIdle;
      r_rdy        <= 1'b0;
      r_pend       <= 1'b0;
      r_err        <= 1'b0;
      r_sof_pend   <= 1'b0;
      r_hold_data  <= '0;
      r_hold_lanes <= '0;
      r_hold_last  <= 1'b0;
      r_hold_vld   <= 1'b0;
      r_lane       <= '0;
      r_out_vld    <= 1'b0;
      r_out_data   <= '0;
      r_out_sof    <= 1'b0;
      r_out_eof    <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_rdy        <= 1'b1;
      r_pend       <= w_pend_d;
      r_err        <= w_err_d;
      r_sof_pend   <= w_sof_pend_d;
      r_hold_data  <= w_hold_data_d;
      r_hold_lanes <= w_hold_lanes_d;
      r_hold_last  <= w_hold_last_d;
      r_hold_vld   <= w_hold_vld_d;
      r_lane       <= w_lane_d;
      r_out_vld    <= w_out_vld_d;
      r_out_data   <= w_out_data_d;
      r_out_sof    <= w_out_sof_d;
      r_out_eof    <= w_out_eof_d;
    end
  end

  assign O_valid     = r_out_vld;
  assign O_data      = r_out_data;
  assign O_sof       = r_out_sof;
  assign O_eof       = r_out_eof;
  assign O_err_trunc = r_err;

endmodule
